// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative inverse cipher.
// Byte 0 of a 128-bit block is [127:120]; bytes are column-major (byte = row + 4*col).
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_INIT,
    ST_ROUND,
    ST_DONE
  } state_e;

  localparam int NR = 10;

  // rcon[1..10], rcon[1] in the top byte.
  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  // Out-of-range indices clamp to the nearest table entry.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [3:0] k;
    if (idx == 4'd0) begin
      k = 4'd1;
    end else if (idx > 4'd10) begin
      k = 4'd10;
    end else begin
      k = idx;
    end
    return RCON_TABLE[8*(4'd10 - k) +: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = gf_xtime(gf_xtime(gf_xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = gf_xtime(b);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = gf_xtime(gf_xtime(b));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
      o[119-32*c -: 8] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
      o[111-32*c -: 8] = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
      o[103-32*c -: 8] = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, purely combinational 256-entry lookup.
module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y_o = INV_SBOX[{~a_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational 256-entry lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a occupies bits [8*(255-a)+7 -: 8], i.e. an MSB index of {~a, 3'b111}.
  assign y_o = SBOX[{~a_i, 3'b111} -: 8];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: forward-expands rk0 to rk10, then one inverse round per clock.
// Define AES_DEC_KEY_CACHE_EN to keep the last rk10 and skip expansion on a repeated key.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              key_valid_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] ct_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] pt_o,
  output logic              busy_o
);

  localparam logic [3:0] LastRnd = 4'(NR);

  state_e            state_q;
  logic [3:0]        rnd_q;
  logic [DATA_W-1:0] roundKey_q;
  logic [DATA_W-1:0] cipherState_q;
  logic [DATA_W-1:0] ptOut_q;
  logic              inReady_q;
  logic              outValid_q;
  logic              busy_q;

  logic              accept;
  logic [31:0]       w0, w1, w2, w3;
  logic [31:0]       invW3, subIn, subOut, rconWord, keyMix;
  logic [3:0]        rconIdx;
  logic [127:0]      expandKey_d, invKey_d;
  logic [127:0]      shifted, subbed, addKey, roundState_d;

  assign accept = in_valid_i & inReady_q & key_valid_i;

  // One SubWord serves both directions: forward uses w3, the reverse step uses the recovered w3.
  assign {w0, w1, w2, w3} = roundKey_q;
  assign invW3    = w3 ^ w2;
  assign subIn    = (state_q == ST_ROUND) ? rot_word(invW3) : rot_word(w3);
  assign rconIdx  = (state_q == ST_ROUND) ? rnd_q + 4'd1 : rnd_q;
  assign rconWord = {rcon(rconIdx), 24'h000000};
  assign keyMix   = w0 ^ subOut ^ rconWord;

  for (genvar i = 0; i < 4; i++) begin : g_key_sbox
    aes_sbox u_sbox (
      .a_i(subIn[8*i +: 8]),
      .y_o(subOut[8*i +: 8])
    );
  end

  assign expandKey_d = {keyMix, w1 ^ keyMix, w2 ^ w1 ^ keyMix, w3 ^ w2 ^ w1 ^ keyMix};
  assign invKey_d    = {keyMix, w1 ^ w0, w2 ^ w1, invW3};

  assign shifted = inv_shift_rows(cipherState_q);

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_inv_sbox u_inv_sbox (
      .a_i(shifted[8*i +: 8]),
      .y_o(subbed[8*i +: 8])
    );
  end

  assign addKey       = subbed ^ invKey_d;
  assign roundState_d = (rnd_q == 4'd0) ? addKey : inv_mix_columns(addKey);

`ifdef AES_DEC_KEY_CACHE_EN
  logic              cacheVld_q;
  logic [DATA_W-1:0] cacheKey_q;
  logic [DATA_W-1:0] cacheRk_q;
  logic              cacheHit;

  assign cacheHit = cacheVld_q && (key_i == cacheKey_q);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      rnd_q         <= 4'd0;
      roundKey_q    <= '0;
      cipherState_q <= '0;
      ptOut_q       <= '0;
      inReady_q     <= 1'b1;
      outValid_q    <= 1'b0;
      busy_q        <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      cacheVld_q    <= 1'b0;
      cacheKey_q    <= '0;
      cacheRk_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cipherState_q <= ct_i;
            inReady_q     <= 1'b0;
            busy_q        <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cacheHit) begin
              roundKey_q <= cacheRk_q;
              rnd_q      <= LastRnd;
              state_q    <= ST_INIT;
            end else begin
              roundKey_q <= key_i;
              rnd_q      <= 4'd1;
              cacheKey_q <= key_i;
              cacheVld_q <= 1'b0;
              state_q    <= ST_EXPAND;
            end
`else
            roundKey_q <= key_i;
            rnd_q      <= 4'd1;
            state_q    <= ST_EXPAND;
`endif
          end
        end
        ST_EXPAND: begin
          roundKey_q <= expandKey_d;
          if (rnd_q == LastRnd) begin
            state_q <= ST_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
            cacheRk_q  <= expandKey_d;
            cacheVld_q <= 1'b1;
`endif
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        ST_INIT: begin
          cipherState_q <= cipherState_q ^ roundKey_q;
          rnd_q         <= LastRnd - 4'd1;
          state_q       <= ST_ROUND;
        end
        ST_ROUND: begin
          cipherState_q <= roundState_d;
          roundKey_q    <= invKey_d;
          if (rnd_q == 4'd0) begin
            ptOut_q    <= roundState_d;
            outValid_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_DONE;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = inReady_q;
  assign out_valid_o = outValid_q;
  assign busy_o      = busy_q;
  assign pt_o        = ptOut_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS-197 vectors, protocol corners and random blocks
// against a textbook AES-128 decryption model; honours AES_DEC_KEY_CACHE_EN for expected latency.
module tb_aes_inv_cipher_iter;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;
  logic         busy;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] sboxT    [256];
  logic [7:0] invSboxT [256];

`ifdef AES_DEC_KEY_CACHE_EN
  bit           cacheValid = 1'b0;
  logic [127:0] cacheKey   = '0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_cipher_iter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .key_valid_i(key_valid),
    .key_i      (key),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .ct_i       (ct),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .pt_o       (pt),
    .busy_o     (busy)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-boxes derived from the field inverse plus the affine map, independent of the RTL tables.
  task automatic buildTables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sboxT[x] = s;
    end
    for (int x = 0; x < 256; x++) invSboxT[sboxT[x]] = 8'(x);
  endtask

  function automatic logic [127:0] refDecrypt(input logic [127:0] k, input logic [127:0] c);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] o;
    int           coef [4];
    coef = '{14, 11, 13, 9};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sboxT[tmp[23:16]], sboxT[tmp[15:8]], sboxT[tmp[7:0]], sboxT[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        s[r][cc] = c[127-8*(r+4*cc) -: 8] ^ w[40+cc][31-8*r -: 8];
    for (int round = 9; round >= 0; round--) begin
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++)
          t[r][cc] = invSboxT[s[r][(cc-r+4)%4]] ^ w[4*round+cc][31-8*r -: 8];
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++) begin
          if (round == 0) begin
            s[r][cc] = t[r][cc];
          end else begin
            s[r][cc] = 8'h00;
            for (int j = 0; j < 4; j++) s[r][cc] = s[r][cc] ^ gmul(8'(coef[(j-r+4)%4]), t[j][cc]);
          end
        end
    end
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        o[127-8*(r+4*cc) -: 8] = s[r][cc];
    return o;
  endfunction

  // Runs one block from the IDLE negedge through release back to IDLE.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c, input logic [127:0] expPt,
                               input int keyDelay, input int holdCycles, input string tag);
    int expLat;
    int lat;
    expLat = 21;
`ifdef AES_DEC_KEY_CACHE_EN
    if (cacheValid && cacheKey == k) expLat = 11;
`endif
    in_valid  = 1'b1;
    ct        = c;
    key       = k;
    key_valid = (keyDelay == 0);
    for (int i = 0; i < keyDelay; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "/nokey_ctrl"}, 128'({in_ready, busy, out_valid}), 128'(3'b100));
    end
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    ct        = {$urandom(), $urandom(), $urandom(), $urandom()};
    key       = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_valid = 1'($urandom_range(0, 1));
    checkOutput({tag, "/accepted_ctrl"}, 128'({in_ready, busy, out_valid}), 128'(3'b010));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checkOutput({tag, "/latency"}, 128'(lat), 128'(expLat));
    if (!out_valid) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
      cacheValid = 1'b0;
`endif
      return;
    end
`ifdef AES_DEC_KEY_CACHE_EN
    cacheValid = 1'b1;
    cacheKey   = k;
`endif
    checkOutput({tag, "/pt"}, pt, expPt);
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "/hold_ctrl"}, 128'({out_valid, in_ready, busy}), 128'(3'b100));
      checkOutput({tag, "/hold_pt"}, pt, expPt);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "/release_ctrl"}, 128'({out_valid, in_ready, busy}), 128'(3'b010));
  endtask

  // Starts a block and pulls reset just after its 15th edge.
  task automatic abortBlock(input logic [127:0] k, input logic [127:0] c);
    in_valid  = 1'b1;
    key_valid = 1'b1;
    key       = k;
    ct        = c;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("abort/busy_before", 128'(busy), 128'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort/ctrl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    checkOutput("abort/pt", pt, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
    cacheValid = 1'b0;
`endif
    @(negedge clk);
  endtask

  // Main sequence: reset, directed vectors, abort, key wait, then random blocks.
  initial begin
    logic [127:0] rk, rc, prevKey;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key       = '0;
    ct        = '0;
    buildTables();
    repeat (2) @(negedge clk);
    checkOutput("reset/ctrl", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    checkOutput("reset/pt", pt, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(C1_KEY, C1_CT, C1_PT, 0, 0, "C1");
    applyStimulus(B_KEY, B_CT, B_PT, 0, 5, "AppB_backpressure");
    abortBlock(C1_KEY, C1_CT);
    applyStimulus(C1_KEY, C1_CT, C1_PT, 0, 0, "C1_after_reset");
    applyStimulus(C1_KEY, C1_CT, C1_PT, 10, 0, "C1_repeat_keywait");
    applyStimulus(B_KEY, B_CT, B_PT, 0, 1, "AppB_again");

    prevKey = B_KEY;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) rk = prevKey;
      else rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(rk, rc, refDecrypt(rk, rc), $urandom_range(0, 2), $urandom_range(0, 3), "random");
      prevKey = rk;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
